// File: rtl/mcwl_pkg.sv
// mcwl_pkg: shared FSM state, tag bit positions and clog2 helper for the window loader
package mcwl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_FLT, WAIT_ROW, STREAM, ROW_END, DONE} state_t;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int tag_start(input int dw);
    return dw + 1;
  endfunction
  function automatic int tag_end(input int dw);
    return dw;
  endfunction
endpackage

// File: rtl/loader_channel_buf.sv
// loader_channel_buf: circular IFMap scratchpad with occupancy count and row start/end queues
module loader_channel_buf import mcwl_pkg::*; #(
  parameter int DW = 16,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW+1:0] din,
  input  logic          wen,
  input  logic          free,
  input  logic [AW-1:0] raddr,
  output logic          ready,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   occ,
  output logic [AW-1:0] head,
  output logic [AW:0]   len,
  output logic          sv,
  output logic          ev
);
  localparam int TS = tag_start(DW);
  localparam int TE = tag_end(DW);
  logic [DW-1:0] spad [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] sq [2];
  logic [AW-1:0] eq [2];
  logic [1:0] sc, ec;
  logic acc;
  assign acc = wen && ready;
  assign ready = occ < (AW+1)'(DEPTH) && sc != 2'd2 && ec != 2'd2;
  assign rdata = spad[raddr];
  assign head = sq[0];
  assign sv = sc != 2'd0;
  assign ev = ec != 2'd0;
  assign len = {1'b0, eq[0] - sq[0]} + (AW+1)'(1);
  always_ff @(posedge clk)
    if (acc) spad[wptr] <= din[DW-1:0];
  always_ff @(posedge clk)
    if (rst) begin
      wptr <= '0;
      occ <= '0;
      sc <= '0;
      ec <= '0;
    end else begin
      wptr <= acc ? (wptr == AW'(DEPTH - 1) ? '0 : wptr + AW'(1)) : wptr;
      occ <= occ + (AW+1)'(acc) - (free ? len : '0);
      if (free) begin
        sq[0] <= sq[1];
        eq[0] <= eq[1];
      end
      if (acc && din[TS]) sq[sc[0] ^ free] <= wptr;
      if (acc && din[TE]) eq[ec[0] ^ free] <= wptr;
      sc <= sc + 2'(acc && din[TS]) - 2'(free);
      ec <= ec + 2'(acc && din[TE]) - 2'(free);
    end
endmodule

// File: rtl/multi_channel_window_loader.sv
// multi_channel_window_loader: emits (ifmap, filter) tap pairs for sliding windows over tagged multi-channel rows
module multi_channel_window_loader import mcwl_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int DW = 16,
  parameter int FW = 16,
  parameter int IF_DEPTH = 16,
  parameter int FLT_DEPTH = 32,
  parameter int ROW_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [clog2(IF_DEPTH)-1:0]    cfg_stride,
  input  logic [clog2(FLT_DEPTH)-1:0]   cfg_fsize,
  input  logic [clog2(NUM_CH):0]        cfg_nch,
  input  logic [ROW_W-1:0]              cfg_rows,
  input  logic                          cfg_zskip,
  input  logic [NUM_CH*(DW+2)-1:0]      if_din,
  input  logic [NUM_CH-1:0]             if_wen,
  output logic [NUM_CH-1:0]             if_ready,
  input  logic [FW-1:0]                 flt_din,
  input  logic                          flt_wen,
  output logic                          flt_ready,
  output logic [DW-1:0]                 out_if,
  output logic [FW-1:0]                 out_flt,
  output logic [clog2(NUM_CH)-1:0]      out_ch,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          done
);
  localparam int IF_AW = clog2(IF_DEPTH);
  localparam int FLT_AW = clog2(FLT_DEPTH);
  localparam int CW = clog2(NUM_CH);
  localparam int OW = IF_AW + FLT_AW;
  state_t state;
  logic [IF_AW-1:0] stride_q, raddr;
  logic [FLT_AW-1:0] fsize_q, k, faddr;
  logic [CW:0] nch_q;
  logic [ROW_W-1:0] rows_q, rows_done;
  logic zskip_q;
  logic [IF_AW:0] w;
  logic [CW-1:0] ch;
  logic [FLT_AW:0] fcnt, total;
  logic [FW-1:0] flt_spad [FLT_DEPTH];
  logic [NUM_CH-1:0] act, sv, ev, free;
  logic [IF_AW:0] occ [NUM_CH];
  logic [IF_AW:0] len [NUM_CH];
  logic [IF_AW-1:0] head [NUM_CH];
  logic [DW-1:0] rdata [NUM_CH];
  logic [OW-1:0] off, wend;
  logic exhausted, avail, k_last, ch_last, adv, issue, emit;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign act[i] = (CW+1)'(i) < nch_q;
    assign free[i] = state == ROW_END && act[i];
    loader_channel_buf #(.DW(DW), .DEPTH(IF_DEPTH), .AW(IF_AW)) u_buf (
      .clk,
      .rst,
      .din(if_din[i*(DW+2) +: DW+2]),
      .wen(if_wen[i]),
      .free(free[i]),
      .raddr,
      .ready(if_ready[i]),
      .rdata(rdata[i]),
      .occ(occ[i]),
      .head(head[i]),
      .len(len[i]),
      .sv(sv[i]),
      .ev(ev[i])
    );
  end
  assign total = (FLT_AW+1)'(nch_q) * (FLT_AW+1)'(fsize_q);
  assign off = OW'(w) + OW'(k);
  assign wend = OW'(w) + OW'(fsize_q);
  assign raddr = IF_AW'((IF_AW+1)'(head[ch]) + (IF_AW+1)'(off));
  assign faddr = FLT_AW'(ch) * fsize_q + k;
  assign exhausted = ev[ch] && wend > OW'(len[ch]);
  assign avail = ev[ch] || off < OW'(occ[ch]);
  assign k_last = k == fsize_q - FLT_AW'(1);
  assign ch_last = {1'b0, ch} == nch_q - (CW+1)'(1);
  assign adv = out_ready || !out_valid;
  assign issue = state == STREAM && !exhausted && avail && adv;
  assign emit = issue && !(zskip_q && rdata[ch] == '0 && !(k_last && ch_last));
  assign flt_ready = state == LOAD_FLT;
  assign done = state == DONE;
  always_ff @(posedge clk)
    if (state == LOAD_FLT && flt_wen) flt_spad[fcnt[FLT_AW-1:0]] <= flt_din;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      {stride_q, fsize_q, nch_q, rows_q, zskip_q} <= '0;
      {fcnt, rows_done, w, k, ch} <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          stride_q <= cfg_stride == '0 ? IF_AW'(1) : cfg_stride;
          fsize_q <= cfg_fsize;
          nch_q <= cfg_nch;
          rows_q <= cfg_rows;
          zskip_q <= cfg_zskip;
          {fcnt, rows_done, w, k, ch} <= '0;
          state <= LOAD_FLT;
        end
        LOAD_FLT: if (flt_wen) begin
          fcnt <= fcnt + (FLT_AW+1)'(1);
          if (fcnt + (FLT_AW+1)'(1) == total) state <= WAIT_ROW;
        end
        WAIT_ROW: if (&(sv | ~act)) state <= STREAM;
        STREAM: if (issue) begin
          k <= k_last ? '0 : k + FLT_AW'(1);
          if (k_last) ch <= ch_last ? '0 : ch + CW'(1);
          if (k_last && ch_last) w <= w + (IF_AW+1)'(stride_q);
        end else if (exhausted && &(ev | ~act)) state <= ROW_END;
        ROW_END: begin
          {w, k, ch} <= '0;
          rows_done <= rows_done + ROW_W'(1);
          state <= rows_done + ROW_W'(1) == rows_q ? DONE : WAIT_ROW;
        end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (rst) begin
      {out_valid, out_last, out_if, out_flt, out_ch} <= '0;
    end else if (adv) begin
      out_valid <= emit;
      if (emit) begin
        out_if <= rdata[ch];
        out_flt <= flt_spad[faddr];
        out_ch <= ch;
        out_last <= k_last && ch_last;
      end
    end
endmodule
